uart_boot_loader: RTL and testbench

// - Sits between the UART AXI-Stream byte interface and the instruction-memory write port of stage_fetch.
// - Receives a framed program image over UART, writes it word-by-word into imem, and verifies a checksum.
// - Answers ACK/NAK on the UART TX stream.
// - Holds the core (cpu_hold) until the first successful load completes.

---
 rtl/boot_pkg.sv | 16 +
 rtl/boot_word_packer.sv | 52 +++++
 rtl/uart_boot_loader.sv | 178 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and protocol constants for the UART boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        RESP
    } boot_state_t;

    localparam logic [7:0] BOOT_ACK   = 8'h06;
    localparam logic [7:0] BOOT_NAK   = 8'h15;
    localparam logic [7:0] BOOT_MAGIC = 8'hA5;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles little-endian bytes into 32-bit words; also exposes the word
// being completed so the caller can act on it in the same cycle.
module boot_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        emit,
    output logic [1:0]  byte_idx,
    output logic        last_byte,
    output logic [31:0] word_next,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shreg;

    assign last_byte = byte_valid && (byte_idx == 2'd3);
    assign word_next = {byte_data, shreg};

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= '0;
            shreg      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_idx <= '0;
                shreg    <= '0;
            end else if (byte_valid) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: shreg[7:0]   <= byte_data;
                    2'd1: shreg[15:8]  <= byte_data;
                    2'd2: shreg[23:16] <= byte_data;
                    default: begin
                        shreg <= '0;
                        // Only data words reach the output register; length words are consumed via word_next.
                        if (emit) begin
                            word       <= word_next;
                            word_valid <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a framed program image over the UART byte stream, writes it into
// imem, verifies the byte checksum and answers ACK/NAK; holds the core until a good load.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  MAGIC          = BOOT_MAGIC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [31:0]           imem_wr_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [32:0]  MAX_WORDS = 33'(1) << ADDR_WIDTH;
    localparam int unsigned  TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);

    boot_state_t         state, state_n;
    logic [7:0]          resp_q, resp_n;
    logic [7:0]          sum_q;
    logic [ADDR_WIDTH:0] word_idx;
    logic [ADDR_WIDTH:0] len_q;
    logic [TW-1:0]       tcnt;

    logic        accept;
    logic        timed;
    logic        expire;
    logic        clear_frame;
    logic        pk_valid;
    logic        pk_last;
    logic [1:0]  pk_idx;
    logic [31:0] pk_next;

    assign s_axis_tready = (state != RESP);
    assign m_axis_tvalid = (state == RESP);
    assign m_axis_tdata  = resp_q;

    assign accept   = s_axis_tvalid && s_axis_tready;
    assign timed    = (state == LEN) || (state == DATA) || (state == CSUM);
    assign expire   = timed && !accept && (tcnt == T_LAST);
    assign pk_valid = accept && ((state == LEN) || (state == DATA));

    boot_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear_frame),
        .byte_valid (pk_valid),
        .byte_data  (s_axis_tdata),
        .emit       (state == DATA),
        .byte_idx   (pk_idx),
        .last_byte  (pk_last),
        .word_next  (pk_next),
        .word       (imem_wr_data),
        .word_valid (imem_wr_en)
    );

    always_comb begin
        state_n     = state;
        resp_n      = resp_q;
        clear_frame = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (s_axis_tdata == MAGIC)) begin
                    state_n     = LEN;
                    clear_frame = 1'b1;
                end
            end
            LEN: begin
                if (pk_last) begin
                    if (pk_next == '0) begin
                        state_n = CSUM;
                    end else if ({1'b0, pk_next} > MAX_WORDS) begin
                        state_n = RESP;
                        resp_n  = BOOT_NAK;
                    end else begin
                        state_n = DATA;
                    end
                end else if (expire) begin
                    state_n = RESP;
                    resp_n  = BOOT_NAK;
                end
            end
            DATA: begin
                if (pk_last && ((word_idx + 1'b1) == len_q)) begin
                    state_n = CSUM;
                end else if (expire) begin
                    state_n = RESP;
                    resp_n  = BOOT_NAK;
                end
            end
            CSUM: begin
                if (accept) begin
                    state_n = RESP;
                    resp_n  = (s_axis_tdata == sum_q) ? BOOT_ACK : BOOT_NAK;
                end else if (expire) begin
                    state_n = RESP;
                    resp_n  = BOOT_NAK;
                end
            end
            RESP: begin
                if (m_axis_tready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            resp_q       <= '0;
            sum_q        <= '0;
            word_idx     <= '0;
            len_q        <= '0;
            tcnt         <= '0;
            imem_wr_addr <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            state  <= state_n;
            resp_q <= resp_n;

            // Idle time is only measured while the state is stable and no byte arrives.
            if (!timed || accept || (state_n != state)) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            if (clear_frame) begin
                sum_q      <= '0;
                word_idx   <= '0;
                cpu_hold   <= 1'b1;
                load_done  <= 1'b0;
                load_error <= 1'b0;
            end

            if ((state == LEN) && pk_last) begin
                len_q <= pk_next[ADDR_WIDTH:0];
            end

            if ((state == DATA) && accept) begin
                sum_q <= sum_q + s_axis_tdata;
                if (pk_last) begin
                    imem_wr_addr <= word_idx[ADDR_WIDTH-1:0];
                    word_idx     <= word_idx + 1'b1;
                end
            end

            if ((state == RESP) && m_axis_tready) begin
                if (resp_q == BOOT_ACK) begin
                    load_done <= 1'b1;
                    cpu_hold  <= 1'b0;
                end else begin
                    load_error <= 1'b1;
                end
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^pk_idx;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: expected imem writes and TX bytes
// are queued as frames are sent and compared as the loader produces them.
module tb_uart_boot_loader;

    localparam int unsigned AW = 10;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [7:0]    m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [31:0]   imem_wr_data;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;

    int checks   = 0;
    int failures = 0;

    logic [7:0]    tx_q[$];
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];

    uart_boot_loader #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO),
        .MAGIC          (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .imem_wr_en    (imem_wr_en),
        .imem_wr_addr  (imem_wr_addr),
        .imem_wr_data  (imem_wr_data),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_error    (load_error)
    );

    always #5 clk = ~clk;

    // Output monitor: pops the scoreboard whenever the loader emits something.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_wr_en) begin
                checks++;
                if (wa_q.size() == 0) begin
                    failures++;
                    $display("FAIL imem_write: unexpected write addr=%0h data=%h", imem_wr_addr, imem_wr_data);
                end else begin
                    logic [AW-1:0] ea;
                    logic [31:0]   ed;
                    ea = wa_q.pop_front();
                    ed = wd_q.pop_front();
                    if (imem_wr_addr !== ea || imem_wr_data !== ed) begin
                        failures++;
                        $display("FAIL imem_write: got addr=%0h data=%h required addr=%0h data=%h",
                                 imem_wr_addr, imem_wr_data, ea, ed);
                    end
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (tx_q.size() == 0) begin
                    failures++;
                    $display("FAIL tx_byte: unexpected TX byte %h", m_axis_tdata);
                end else begin
                    logic [7:0] et;
                    et = tx_q.pop_front();
                    if (m_axis_tdata !== et) begin
                        failures++;
                        $display("FAIL tx_byte: got %h required %h", m_axis_tdata, et);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) begin
            checks++;
            failures++;
            $display("FAIL send_byte: s_axis_tready=%b required 1 within 200 cycles", s_axis_tready);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i]);
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
        wa_q.push_back(a);
        wd_q.push_back(d);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || wa_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (tx_q.size() != 0 || wa_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: pending tx=%0d writes=%0d required 0", name, tx_q.size(), wa_q.size());
            tx_q.delete();
            wa_q.delete();
            wd_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string name, input logic h, input logic d, input logic e);
        checks++;
        if (cpu_hold !== h || load_done !== d || load_error !== e) begin
            failures++;
            $display("FAIL %s_flags: got hold=%b done=%b err=%b required hold=%b done=%b err=%b",
                     name, cpu_hold, load_done, load_error, h, d, e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 ||
            imem_wr_en !== 1'b0 || imem_wr_addr !== '0 || imem_wr_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b tv=%b td=%h we=%b wa=%h wd=%h required 1 0 00 0 0 0",
                     s_axis_tready, m_axis_tvalid, m_axis_tdata, imem_wr_en, imem_wr_addr, imem_wr_data);
        end
        check_flags("reset", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_happy();
        expect_write(10'd0, 32'h00000013);
        expect_write(10'd1, 32'h00100093);
        tx_q.push_back(8'h06);
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                     8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6});
        drain("happy");
        check_flags("happy", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_bad_csum();
        expect_write(10'd0, 32'h00000013);
        expect_write(10'd1, 32'h00100093);
        tx_q.push_back(8'h15);
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                     8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00});
        drain("bad_csum");
        check_flags("bad_csum", 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_empty_oversize();
        tx_q.push_back(8'h06);
        send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        drain("empty");
        check_flags("empty", 1'b0, 1'b1, 1'b0);

        tx_q.push_back(8'h15);
        send_bytes('{8'hA5, 8'h01, 8'h04, 8'h00});
        send_byte(8'h00);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h15) begin
            failures++;
            $display("FAIL oversize_immediate: got tvalid=%b tdata=%h required 1 15", m_axis_tvalid, m_axis_tdata);
        end
        drain("oversize");
        check_flags("oversize", 1'b1, 1'b0, 1'b1);
    endtask

    task automatic wait_timeout(input string name);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 15 || k == 16) begin
                checks++;
                if (m_axis_tvalid !== (k == 16)) begin
                    failures++;
                    $display("FAIL %s_cycle%0d: tvalid=%b required %b", name, k, m_axis_tvalid, (k == 16));
                end
            end
        end
    endtask

    task automatic test_timeout();
        tx_q.push_back(8'h15);
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11});
        send_byte(8'h22);
        wait_timeout("timeout");
        drain("timeout");
        check_flags("timeout", 1'b1, 1'b0, 1'b1);

        tx_q.push_back(8'h15);
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11});
        send_byte(8'h22);
        repeat (15) @(posedge clk);
        send_byte(8'h33);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_restart: tvalid=%b required 0 after byte in expiry cycle", m_axis_tvalid);
        end
        wait_timeout("timeout_restart");
        drain("timeout_restart");
    endtask

    task automatic test_back_to_back();
        m_axis_tready = 1'b0;
        expect_write(10'd0, 32'h00000013);
        expect_write(10'd1, 32'h00100093);
        tx_q.push_back(8'h06);
        send_bytes('{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                     8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6});
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h06 || s_axis_tready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_c%0d: got tvalid=%b tdata=%h rdy=%b required 1 06 0",
                         k, m_axis_tvalid, m_axis_tdata, s_axis_tready);
            end
            @(posedge clk);
            #1;
        end
        m_axis_tready = 1'b1;
        drain("backpressure");
        check_flags("backpressure", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_data();
        send_bytes('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00});
        do_reset();
        check_flags("mid_reset", 1'b1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_tx: tvalid=%b required 0", m_axis_tvalid);
        end
        test_happy();
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        test_reset();
        test_happy();
        test_bad_csum();
        test_empty_oversize();
        test_timeout();
        test_back_to_back();
        test_reset_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
